// File: rtl/control_merge_rr.sv
// rtl/control_merge_rr.sv - registered arbitrated control merge with eager-fork data/index outputs
module control_merge_rr #(
  parameter int SIZE       = 4,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = 2,
  parameter int ARB_MODE   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [INDEX_TYPE-1:0]     index,
  output logic                      index_valid,
  input  logic                      index_ready
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [IW-1:0]        last;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        idx_reg;
  logic [SIZE-1:0]      grant;
  logic                 found;
  logic [DATA_TYPE-1:0] gdata;
  logic [DATA_TYPE-1:0] data_reg;
  logic                 pend_o;
  logic                 pend_i;
  logic                 free;
  logic                 accept;

  // Arbitration: pick the valid channel with the smallest priority distance.
  // Fixed mode uses the channel number as distance; round-robin measures the
  // distance from the channel just after the last winner, wrapping at SIZE.
  always_comb begin
    int best;
    int gi;
    int d;
    best  = SIZE;
    gi    = 0;
    d     = 0;
    found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (ARB_MODE == 0 || SIZE == 1) begin
        d = i;
      end else begin
        d = i - int'(last) - 1;
        if (d < 0) d = d + SIZE;
      end
      if (ins_valid[i] && d < best) begin
        best  = d;
        gi    = i;
        found = 1'b1;
      end
    end
    gidx  = IW'(gi);
    grant = '0;
    gdata = '0;
    for (int i = 0; i < SIZE; i++) begin
      grant[i] = found && (i == gi);
      if (found && (i == gi)) gdata = ins[i*DATA_TYPE +: DATA_TYPE];
    end
  end

  // The slot can take a new token when every pending output is gone or is
  // being consumed this cycle, which lets a reload happen with no bubble.
  assign free      = (!pend_o || outs_ready) && (!pend_i || index_ready);
  assign ins_ready = grant & {SIZE{free & rst}};
  assign accept    = |(ins_valid & ins_ready);

  generate
    if (SIZE > 1 && ARB_MODE != 0) begin : g_ptr
      // Round-robin pointer: moves only when a token is accepted.
      always_ff @(posedge clk) begin
        if (!rst) last <= IW'(SIZE - 1);
        else if (accept) last <= gidx;
      end
    end else begin : g_noptr
      assign last = '0;
    end
  endgenerate

  // Output slot: load on accept, otherwise retire each fork branch independently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg <= '0;
      idx_reg  <= '0;
      pend_o   <= 1'b0;
      pend_i   <= 1'b0;
    end else if (accept) begin
      data_reg <= gdata;
      idx_reg  <= gidx;
      pend_o   <= 1'b1;
      pend_i   <= 1'b1;
    end else begin
      if (outs_ready)  pend_o <= 1'b0;
      if (index_ready) pend_i <= 1'b0;
    end
  end

  assign outs        = data_reg;
  assign outs_valid  = pend_o;
  assign index       = INDEX_TYPE'(idx_reg);
  assign index_valid = pend_i;

endmodule

// File: tb/tb_control_merge_rr.sv
// tb/tb_control_merge_rr.sv - randomized and directed bench for control_merge_rr (fixed and round-robin)
module tb_control_merge_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ins;
  logic [3:0]   ins_valid;
  logic         outs_ready;
  logic         index_ready;

  logic [3:0]   ird_f, ird_r;
  logic [31:0]  outs_f, outs_r;
  logic         ov_f, ov_r, iv_f, iv_r;
  logic [1:0]   idx_f, idx_r;

  int pass_cnt = 0;
  int total_cnt = 0;

  // model state per arbiter: 0 = fixed priority, 1 = round-robin
  int          m_last [2];
  bit          m_po   [2];
  bit          m_pi   [2];
  logic [31:0] m_data [2];
  int          m_idx  [2];

  always #5 clk = ~clk;

  control_merge_rr #(.SIZE(4), .DATA_TYPE(32), .INDEX_TYPE(2), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ird_f),
    .outs(outs_f), .outs_valid(ov_f), .outs_ready(outs_ready),
    .index(idx_f), .index_valid(iv_f), .index_ready(index_ready));

  control_merge_rr #(.SIZE(4), .DATA_TYPE(32), .INDEX_TYPE(2), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ird_r),
    .outs(outs_r), .outs_valid(ov_r), .outs_ready(outs_ready),
    .index(idx_r), .index_valid(iv_r), .index_ready(index_ready));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Winning channel under the arbitration rule, or -1 when nothing is valid.
  function automatic int model_grant(input int m);
    int ch;
    for (int k = 0; k < 4; k++) begin
      ch = (m == 0) ? k : (m_last[m] + 1 + k) % 4;
      if (ins_valid[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic bit model_free(input int m);
    return (!m_po[m] || outs_ready) && (!m_pi[m] || index_ready) && rst;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_last[m] = 3; m_po[m] = 0; m_pi[m] = 0; m_data[m] = 0; m_idx[m] = 0;
    end
  endtask

  task automatic model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = model_grant(m);
      if (!rst) begin
        m_last[m] = 3; m_po[m] = 0; m_pi[m] = 0; m_data[m] = 0; m_idx[m] = 0;
      end else if (g >= 0 && model_free(m)) begin
        m_data[m] = ins[g*32 +: 32];
        m_idx[m]  = g;
        m_po[m]   = 1;
        m_pi[m]   = 1;
        if (m == 1) m_last[m] = g;
      end else begin
        if (outs_ready)  m_po[m] = 0;
        if (index_ready) m_pi[m] = 0;
      end
    end
  endtask

  task automatic compare_one(input int m, input logic [3:0] ird, input logic [31:0] o,
                             input logic ov, input logic [1:0] ix, input logic iv);
    int g;
    logic [3:0] exp_rdy;
    g = model_grant(m);
    exp_rdy = (g >= 0 && model_free(m)) ? 4'(1 << g) : 4'b0;
    check($sformatf("m%0d_ins_ready", m), 64'(ird), 64'(exp_rdy));
    check($sformatf("m%0d_outs_valid", m), 64'(ov), 64'(m_po[m]));
    check($sformatf("m%0d_index_valid", m), 64'(iv), 64'(m_pi[m]));
    check($sformatf("m%0d_outs", m), 64'(o), 64'(m_data[m]));
    check($sformatf("m%0d_index", m), 64'(ix), 64'(m_idx[m]));
  endtask

  // Apply inputs, check against the model, then advance through one clock edge.
  task automatic drive(input logic r, input logic [3:0] v, input logic ordy, input logic irdy);
    rst = r; ins_valid = v; outs_ready = ordy; index_ready = irdy;
    #1;
    compare_one(0, ird_f, outs_f, ov_f, idx_f, iv_f);
    compare_one(1, ird_r, outs_r, ov_r, idx_r, iv_r);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) ins[i*32 +: 32] = base + 32'(i);
  endtask

  initial begin
    rst = 0; ins_valid = 0; outs_ready = 0; index_ready = 0; ins = '0;
    model_reset();
    @(negedge clk);

    // reset hold with all inputs valid
    set_data(32'd10);
    rst = 0; ins_valid = 4'b1111; outs_ready = 1; index_ready = 1;
    @(posedge clk); @(negedge clk);
    check("rst_ready_rr", 64'(ird_r), 64'd0);
    check("rst_ready_fp", 64'(ird_f), 64'd0);
    check("rst_ovalid", 64'(ov_r), 64'd0);
    check("rst_ivalid", 64'(iv_r), 64'd0);
    drive(0, 4'b1111, 1, 1);

    // round-robin fairness: 0,1,2,3,0 at one token per cycle
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'b1111, 1, 1);
      check("rr_seq_idx", 64'(idx_r), 64'(k % 4));
      check("rr_seq_outs", 64'(outs_r), 64'(k % 4 + 10));
      check("rr_seq_valid", 64'(ov_r & iv_r), 64'd1);
      check("fp_seq_idx", 64'(idx_f), 64'd0);
    end

    // fixed priority with channels 1 and 3 valid
    drive(0, 4'b1010, 1, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'b1010, 1, 1);
      check("fp_1010_idx", 64'(idx_f), 64'd1);
    end

    // fork decoupling: index held, outs retired, no new accept
    drive(0, 4'b0000, 1, 1);
    ins[2*32 +: 32] = 32'hAB;
    drive(1, 4'b0100, 1, 1);
    check("fork_outs", 64'(outs_r), 64'hAB);
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'b0100, 1, 0);
      check("fork_ovalid", 64'(ov_r), 64'd0);
      check("fork_ivalid", 64'(iv_r), 64'd1);
      check("fork_index", 64'(idx_r), 64'd2);
      #1;
      check("fork_blocked", 64'(ird_r), 64'd0);
    end

    // back-to-back reload: outs_valid stays high with no gap
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'b0100, 1, 1);
      check("b2b_ovalid", 64'(ov_r), 64'd1);
    end

    // mid-op reset with a full slot, then ch0 wins first
    drive(1, 4'b0001, 0, 0);
    drive(0, 4'b0001, 0, 0);
    check("midrst_ovalid", 64'(ov_r | ov_f), 64'd0);
    check("midrst_ivalid", 64'(iv_r | iv_f), 64'd0);
    drive(1, 4'b1111, 1, 1);
    check("midrst_first", 64'(idx_r), 64'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) ins[i*32 +: 32] = $urandom;
      drive(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
